// File: rtl/issue_stage_sb_pkg.sv
// Shared pipeline types for the issue stage: default widths, register address/data
// types, scoreboard counter type and the Issue->Execute pipe register layout.
package issue_stage_sb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int PC_W_DEF   = 32;
    localparam int CTRL_W_DEF = 16;
    localparam int NUM_WB_DEF = 2;
    localparam int CNT_W_DEF  = 2;
    localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]   basic_data_t;
    typedef logic [CNT_W_DEF-1:0]  sb_count_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [CTRL_W_DEF-1:0] ctrl;
        reg_addr_t             rd;
        logic                  wen;
        basic_data_t           rs1_data;
        basic_data_t           rs2_data;
    } issue_pipe_reg_t;

    // Largest number of outstanding writers a counter of the given width can track.
    function automatic int unsigned sb_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/issue_stage_sb_scoreboard.sv
// Per-register counted scoreboard: tracks outstanding writers, reports source
// blocking (with single-writer forwarding relief), destination saturation and sb_err.
module issue_scoreboard
    import issue_stage_sb_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_WB = NUM_WB_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rs1,
    input  logic [ADDR_W-1:0]        rs2,
    input  logic [ADDR_W-1:0]        rd,
    input  logic                     issue_inc,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB-1:0]        wb_wen,
    input  logic [NUM_WB*ADDR_W-1:0] wb_rd,
    output logic                     rs1_block,
    output logic                     rs2_block,
    output logic                     rd_full,
    output logic                     sb_err
);

    localparam int RET_W = $clog2(NUM_WB + 1);
    localparam int SUM_W = CNT_W + RET_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sb_max(CNT_W));

    logic [CNT_W-1:0] cnt     [NREGS];
    logic [CNT_W-1:0] cnt_nxt [NREGS];
    logic [RET_W-1:0] ret_cnt [NREGS];
    logic [SUM_W-1:0] up_sum  [NREGS];
    logic [NREGS-1:0] underflow;
    logic             hit1;
    logic             hit2;

    // Retire count per register; x0 never retires so it can never raise sb_err.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            ret_cnt[r] = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (r != 0 && wb_valid[p] && wb_rd[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    ret_cnt[r] = ret_cnt[r] + RET_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            up_sum[r]    = SUM_W'(cnt[r]) + SUM_W'(issue_inc && rd == ADDR_W'(r));
            underflow[r] = up_sum[r] < SUM_W'(ret_cnt[r]);
            cnt_nxt[r]   = underflow[r] ? '0 : CNT_W'(up_sum[r] - SUM_W'(ret_cnt[r]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (|underflow) begin
                sb_err <= 1'b1;
            end
        end
    end

    // A source with exactly one writer left, which is writing back now, is satisfied by bypass.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && wb_wen[p]) begin
                if (wb_rd[p*ADDR_W +: ADDR_W] == rs1) hit1 = 1'b1;
                if (wb_rd[p*ADDR_W +: ADDR_W] == rs2) hit2 = 1'b1;
            end
        end
        rs1_block = rs1 != '0 && cnt[rs1] != '0 && !(cnt[rs1] == CNT_W'(1) && hit1);
        rs2_block = rs2 != '0 && cnt[rs2] != '0 && !(cnt[rs2] == CNT_W'(1) && hit2);
        rd_full   = rd != '0 && cnt[rd] == CNT_MAX && ret_cnt[rd] == '0;
    end

endmodule

// File: rtl/issue_stage_sb.sv
// Decode/issue stage: register file with write-back bypass, counted scoreboard
// hazard check, and the valid/ready pipe register toward Execute with flush.
module issue_stage_sb
    import issue_stage_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int NUM_WB = NUM_WB_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [ADDR_W-1:0]        in_rs1,
    input  logic [ADDR_W-1:0]        in_rs2,
    input  logic                     in_use_rs1,
    input  logic                     in_use_rs2,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic                     in_wen,
    input  logic [CTRL_W-1:0]        in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [ADDR_W-1:0]        out_rd,
    output logic                     out_wen,
    output logic [XLEN-1:0]          out_rs1_data,
    output logic [XLEN-1:0]          out_rs2_data,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB-1:0]        wb_wen,
    input  logic [NUM_WB*ADDR_W-1:0] wb_rd,
    input  logic [NUM_WB*XLEN-1:0]   wb_data,
    output logic                     sb_err
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [ADDR_W-1:0] rd;
        logic              wen;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
    } pipe_reg_t;

    logic [XLEN-1:0] regs [NREGS];
    pipe_reg_t       pipe_q;
    pipe_reg_t       pipe_d;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_block;
    logic            rs2_block;
    logic            rd_full;
    logic            hazard;
    logic            fire;

    issue_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WB (NUM_WB),
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .rd        (in_rd),
        .issue_inc (fire && in_wen && in_rd != '0),
        .wb_valid  (wb_valid),
        .wb_wen    (wb_wen),
        .wb_rd     (wb_rd),
        .rs1_block (rs1_block),
        .rs2_block (rs2_block),
        .rd_full   (rd_full),
        .sb_err    (sb_err)
    );

    assign hazard   = (in_use_rs1 && rs1_block) || (in_use_rs2 && rs2_block) || (in_wen && rd_full);
    assign in_ready = in_valid && !hazard && !flush && (!out_valid || out_ready);
    assign fire     = in_ready;

    // Later write-back ports override earlier ones, matching the register file write order.
    always_comb begin
        rs1_val = regs[in_rs1];
        rs2_val = regs[in_rs2];
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && wb_wen[p]) begin
                if (wb_rd[p*ADDR_W +: ADDR_W] == in_rs1) rs1_val = wb_data[p*XLEN +: XLEN];
                if (wb_rd[p*ADDR_W +: ADDR_W] == in_rs2) rs2_val = wb_data[p*XLEN +: XLEN];
            end
        end
        if (in_rs1 == '0) rs1_val = '0;
        if (in_rs2 == '0) rs2_val = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && wb_wen[p] && wb_rd[p*ADDR_W +: ADDR_W] != '0) begin
                    regs[wb_rd[p*ADDR_W +: ADDR_W]] <= wb_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        pipe_d.pc       = in_pc;
        pipe_d.ctrl     = in_ctrl;
        pipe_d.rd       = in_rd;
        pipe_d.wen      = in_wen;
        pipe_d.rs1_data = rs1_val;
        pipe_d.rs2_data = rs2_val;
    end

    // Contents are held on flush or stall; only reset clears the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pipe_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            pipe_q    <= pipe_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_pc       = pipe_q.pc;
    assign out_ctrl     = pipe_q.ctrl;
    assign out_rd       = pipe_q.rd;
    assign out_wen      = pipe_q.wen;
    assign out_rs1_data = pipe_q.rs1_data;
    assign out_rs2_data = pipe_q.rs2_data;

endmodule

// File: tb/tb_issue_stage_sb.sv
// Directed bench for issue_stage_sb: expected pipe-register contents are queued at
// issue time and checked by an independent monitor when Execute consumes them.
module tb_issue_stage_sb;
    import issue_stage_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_use_rs1;
    logic        in_use_rs2;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [15:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [15:0] out_ctrl;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [1:0]  wb_valid;
    logic [1:0]  wb_wen;
    logic [9:0]  wb_rd;
    logic [63:0] wb_data;
    logic        sb_err;

    issue_pipe_reg_t exp_q[$];
    issue_pipe_reg_t mon_e;
    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    issue_stage_sb dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_use_rs1   (in_use_rs1),
        .in_use_rs2   (in_use_rs2),
        .in_rd        (in_rd),
        .in_wen       (in_wen),
        .in_ctrl      (in_ctrl),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_ctrl     (out_ctrl),
        .out_rd       (out_rd),
        .out_wen      (out_wen),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .wb_valid     (wb_valid),
        .wb_wen       (wb_wen),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .sb_err       (sb_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic wen, input logic [15:0] ctrl);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_rs1 = u1;
        in_use_rs2 = u2;
        in_rd      = rd;
        in_wen     = wen;
        in_ctrl    = ctrl;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [15:0] ctrl, input logic [4:0] rd,
                            input logic wen, input logic [31:0] d1, input logic [31:0] d2);
        issue_pipe_reg_t e;
        e.pc       = pc;
        e.ctrl     = ctrl;
        e.rd       = rd;
        e.wen      = wen;
        e.rs1_data = d1;
        e.rs2_data = d2;
        exp_q.push_back(e);
    endtask

    // Drives one instruction until it fires (bounded); with 'immediate' it must fire at once.
    task automatic issue(input string name, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wen, input logic [15:0] ctrl, input logic [31:0] d1,
                         input logic [31:0] d2, input bit immediate);
        bit done = 1'b0;
        applyStimulus(pc, rs1, rs2, u1, u2, rd, wen, ctrl);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(pc, ctrl, rd, wen, d1, d2);
                done = 1'b1;
            end
            step();
            if (done || immediate) break;
        end
        in_valid = 1'b0;
        checkOutput({name, "_fire"}, 64'(done), 64'd1);
    endtask

    task automatic wb_set(input int p, input logic wen, input logic [4:0] rd, input logic [31:0] data);
        wb_valid[p]          = 1'b1;
        wb_wen[p]            = wen;
        wb_rd[p*5 +: 5]      = rd;
        wb_data[p*32 +: 32]  = data;
    endtask

    task automatic wb_clear();
        wb_valid = '0;
        wb_wen   = '0;
        wb_rd    = '0;
        wb_data  = '0;
    endtask

    // Monitor: a flushed entry is dropped, a consumed entry is compared field by field.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (out_valid && flush) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (out_valid && out_ready) begin
            checkOutput("mon_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("mon_pc",   64'(out_pc),       64'(mon_e.pc));
                checkOutput("mon_ctrl", 64'(out_ctrl),     64'(mon_e.ctrl));
                checkOutput("mon_rd",   64'(out_rd),       64'(mon_e.rd));
                checkOutput("mon_wen",  64'(out_wen),      64'(mon_e.wen));
                checkOutput("mon_rs1",  64'(out_rs1_data), 64'(mon_e.rs1_data));
                checkOutput("mon_rs2",  64'(out_rs2_data), 64'(mon_e.rs2_data));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_use_rs1 = 1'b0;
        in_use_rs2 = 1'b0; in_rd = '0; in_wen = 1'b0; in_ctrl = '0;
        wb_clear();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid),    64'd0);
        checkOutput("rst_out_pc",    64'(out_pc),       64'd0);
        checkOutput("rst_out_ctrl",  64'(out_ctrl),     64'd0);
        checkOutput("rst_out_rs1",   64'(out_rs1_data), 64'd0);
        checkOutput("rst_sb_err",    64'(sb_err),       64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),     64'd0);
        step();

        // Preload x1=5, x2=7 through issued writers retired on both ports together.
        issue("w_x1", 32'h100, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 16'h0011, 32'd0, 32'd0, 1'b1);
        issue("w_x2", 32'h104, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 16'h0012, 32'd0, 32'd0, 1'b1);
        wb_set(0, 1'b1, 5'd1, 32'd5);
        wb_set(1, 1'b1, 5'd2, 32'd7);
        step();
        wb_clear();
        issue("add_x3", 32'h108, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 16'h00A1, 32'd5, 32'd7, 1'b1);
        @(negedge clk);
        checkOutput("add_out_valid", 64'(out_valid),    64'd1);
        checkOutput("add_out_rs1",   64'(out_rs1_data), 64'd5);
        checkOutput("add_out_rs2",   64'(out_rs2_data), 64'd7);
        step();

        // RAW on x3: stall until its single writer retires, then take the bypassed value.
        applyStimulus(32'h10C, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 16'h00B2);
        @(negedge clk);
        checkOutput("raw_stall_0", 64'(in_ready), 64'd0);
        step();
        @(negedge clk);
        checkOutput("raw_stall_1", 64'(in_ready), 64'd0);
        step();
        wb_set(0, 1'b1, 5'd3, 32'h55);
        @(negedge clk);
        checkOutput("bypass_ready", 64'(in_ready), 64'd1);
        if (in_ready) push_exp(32'h10C, 16'h00B2, 5'd0, 1'b0, 32'h55, 32'd0);
        step();
        wb_clear();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bypass_data", 64'(out_rs1_data), 64'h55);
        step();

        // Saturated counter on x4: the fourth writer waits for a retire, then count stays at max.
        issue("w_x4_a", 32'h110, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 16'h0040, 32'd0, 32'd0, 1'b1);
        issue("w_x4_b", 32'h114, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 16'h0041, 32'd0, 32'd0, 1'b1);
        issue("w_x4_c", 32'h118, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 16'h0042, 32'd0, 32'd0, 1'b1);
        applyStimulus(32'h11C, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 16'h0043);
        @(negedge clk);
        checkOutput("full_stall", 64'(in_ready), 64'd0);
        step();
        wb_set(1, 1'b1, 5'd4, 32'h44);
        @(negedge clk);
        checkOutput("full_retire_ready", 64'(in_ready), 64'd1);
        if (in_ready) push_exp(32'h11C, 16'h0043, 5'd4, 1'b1, 32'd0, 32'd0);
        step();
        wb_clear();
        applyStimulus(32'h120, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 16'h0044);
        @(negedge clk);
        checkOutput("cnt_stays_max", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;

        // Back-pressure holds the output, then flush kills it without touching counters.
        out_ready = 1'b0;
        issue("held", 32'h200, 5'd3, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 16'hBEEF, 32'h55, 32'd5, 1'b1);
        applyStimulus(32'h204, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0204);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("hold_valid",    64'(out_valid),    64'd1);
            checkOutput("hold_pc",       64'(out_pc),       64'h200);
            checkOutput("hold_ctrl",     64'(out_ctrl),     64'hBEEF);
            checkOutput("hold_rs1",      64'(out_rs1_data), 64'h55);
            checkOutput("hold_rs2",      64'(out_rs2_data), 64'd5);
            checkOutput("hold_in_ready", 64'(in_ready),     64'd0);
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        step();
        out_ready = 1'b1;
        applyStimulus(32'h208, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 16'h0045);
        @(negedge clk);
        checkOutput("flush_cnt_kept", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;

        // Two ports retire x6 together: highest-index data wins and the count reaches zero.
        issue("w_x6_a", 32'h300, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 16'h0060, 32'd0, 32'd0, 1'b1);
        issue("w_x6_b", 32'h304, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 16'h0061, 32'd0, 32'd0, 1'b1);
        wb_set(0, 1'b1, 5'd6, 32'd1);
        wb_set(1, 1'b1, 5'd6, 32'd2);
        step();
        wb_clear();
        @(negedge clk);
        checkOutput("dual_wb_err", 64'(sb_err), 64'd0);
        step();
        issue("rd_x6", 32'h308, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0600, 32'd2, 32'd0, 1'b1);
        wb_set(0, 1'b1, 5'd0, 32'hDEAD);
        issue("rd_x0", 32'h30C, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 16'h0601, 32'd0, 32'd0, 1'b1);
        wb_clear();
        @(negedge clk);
        checkOutput("wb_x0_no_err", 64'(sb_err), 64'd0);
        step();
        wb_set(0, 1'b1, 5'd6, 32'd9);
        step();
        wb_clear();
        @(negedge clk);
        checkOutput("underflow_err", 64'(sb_err), 64'd1);
        step();
        step();
        @(negedge clk);
        checkOutput("err_sticky", 64'(sb_err), 64'd1);
        step();

        // Reset mid-operation with two writers of x5 outstanding and a held output.
        issue("w_x5_a", 32'h400, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 16'h0050, 32'd0, 32'd0, 1'b1);
        issue("w_x5_b", 32'h404, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 16'h0051, 32'd0, 32'd0, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_out_pc",    64'(out_pc),    64'd0);
        checkOutput("mid_rst_out_rd",    64'(out_rd),    64'd0);
        checkOutput("mid_rst_out_ctrl",  64'(out_ctrl),  64'd0);
        checkOutput("mid_rst_sb_err",    64'(sb_err),    64'd0);
        step();
        out_ready = 1'b1;
        issue("rd_x5_after_rst", 32'h500, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 16'h0700, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        step();
        @(negedge clk);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
